// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: 4x4 active-low matrix scanner with whole-frame debounce
// and single-cycle press/release strobes on a held-key state machine.
module keypad_scan_debounce #(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] LINE,
    input  logic [3:0] COLLUMMN,
    output logic [3:0] keyword,
    output logic [1:0] flag_pressed
);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_FRAMES);
    // Nibble {row,col} holds the code: row0 1 2 3 A, row1 4 5 6 B, row2 7 8 9 C, row3 * 0 # D
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [2:0] {S_IDLE, S_PRESS, S_HELD, S_REL, S_ROLL} state_t;

    logic [1:0]    r_row;
    logic [SW-1:0] r_settle;
    logic [3:0]    r_line;
    logic [1:0]    r_hits;
    logic [3:0]    r_code;
    logic          r_frame_done;
    logic          r_cand_v;
    logic [3:0]    r_cand;
    logic [DW-1:0] r_dcnt;
    state_t        r_state, w_state_nx;
    logic [3:0]    r_key, w_key_nx;
    logic [1:0]    r_flag, w_flag_nx;

    logic [2:0] w_row_cnt;
    logic [1:0] w_col;
    logic [2:0] w_sum;
    logic [1:0] w_tot;
    logic [3:0] w_map;
    logic [3:0] w_code;
    logic       w_last;
    logic       w_frame_end;
    logic       w_res_v;
    logic       w_same;
    logic       w_accept;

    always_comb begin
        w_row_cnt = 3'd0;
        w_col     = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (!COLLUMMN[c]) begin
                w_row_cnt = w_row_cnt + 3'd1;
                w_col     = 2'(c);
            end
        end
    end

    // Hit count saturates at 2: anything above one key in a frame is rejected
    assign w_sum       = {1'b0, r_hits} + w_row_cnt;
    assign w_tot       = (w_sum > 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_map       = KEYMAP[{r_row, w_col, 2'b00} +: 4];
    assign w_code      = (w_row_cnt == 3'd1) ? w_map : r_code;
    assign w_last      = r_settle == SETTLE_LAST;
    assign w_frame_end = w_last && r_row == 2'd3;
    assign w_res_v     = w_tot == 2'd1;
    assign w_same      = (w_res_v == r_cand_v) && (!w_res_v || w_code == r_cand);
    assign w_accept    = r_frame_done && r_dcnt == DB_MAX;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row        <= 2'd0;
            r_settle     <= '0;
            r_line       <= 4'b1110;
            r_hits       <= 2'd0;
            r_code       <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_last) begin
                r_settle <= '0;
                r_row    <= r_row + 2'd1;
                r_line   <= {r_line[2:0], r_line[3]};
                r_hits   <= (r_row == 2'd3) ? 2'd0 : w_tot;
                r_code   <= w_code;
            end else begin
                r_settle <= r_settle + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand_v <= 1'b0;
            r_cand   <= 4'd0;
            r_dcnt   <= '0;
        end else if (w_frame_end) begin
            if (w_same) begin
                r_dcnt <= (r_dcnt == DB_MAX) ? r_dcnt : r_dcnt + DW'(1);
            end else begin
                r_cand_v <= w_res_v;
                r_cand   <= w_code;
                r_dcnt   <= DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_key   <= 4'd0;
            r_flag  <= 2'b00;
        end else begin
            r_state <= w_state_nx;
            r_key   <= w_key_nx;
            r_flag  <= w_flag_nx;
        end
    end

    // A rollover passes through S_ROLL so the release strobe precedes the new press
    always_comb begin
        w_state_nx = r_state;
        w_key_nx   = r_key;
        w_flag_nx  = r_flag;
        case (r_state)
            S_IDLE: if (w_accept && r_cand_v) begin
                w_state_nx = S_PRESS;
                w_key_nx   = r_cand;
                w_flag_nx  = 2'b01;
            end
            S_PRESS: begin
                w_state_nx = S_HELD;
                w_flag_nx  = 2'b10;
            end
            S_HELD: if (w_accept && (!r_cand_v || r_cand != r_key)) begin
                w_state_nx = r_cand_v ? S_ROLL : S_REL;
                w_flag_nx  = 2'b11;
            end
            S_REL: begin
                w_state_nx = S_IDLE;
                w_flag_nx  = 2'b00;
            end
            S_ROLL: begin
                w_state_nx = S_PRESS;
                w_key_nx   = r_cand;
                w_flag_nx  = 2'b01;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_flag_nx  = 2'b00;
            end
        endcase
    end

    assign LINE         = r_line;
    assign keyword      = r_key;
    assign flag_pressed = r_flag;
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: keypad matrix model, strobe scoreboard and
// table-driven key sequences for keypad_scan_debounce.
module tb_keypad_scan_debounce;
    localparam int S     = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * S;

    typedef struct {
        string       name;
        logic [15:0] keys;
        int          frames;
        logic [1:0]  flag;
        logic [3:0]  key;
        int          ns;
        logic [5:0]  s0;
        logic [5:0]  s1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  line;
    logic [3:0]  col;
    logic [3:0]  keyword;
    logic [1:0]  flag_pressed;
    logic [15:0] keys;
    logic [5:0]  exp_q[$];
    logic [5:0]  mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          t01 = -1000;
    int          t11 = -1000;
    int          t0;
    vec_t        tbl[8];

    keypad_scan_debounce #(.SETTLE_CYCLES(S), .DEBOUNCE_FRAMES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .LINE(line), .COLLUMMN(col),
        .keyword(keyword), .flag_pressed(flag_pressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pressed key (r,c) pulls column c low only while row r is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !line[r]) col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (flag_pressed == 2'b01 || flag_pressed == 2'b11) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got flag=%b key=%0d at cycle %0d, required no strobe",
                         flag_pressed, keyword, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({flag_pressed, keyword} !== mon_e) begin
                    errors++;
                    $display("FAIL strobe: got flag=%b key=%0d, required flag=%b key=%0d",
                             flag_pressed, keyword, mon_e[5:4], mon_e[3:0]);
                end
            end
            if (flag_pressed == 2'b01) t01 = cyc;
            else t11 = cyc;
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", n, got, exp);
        end
    endtask

    task automatic chk_q(input string n);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d strobes outstanding, required 0", n, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic chk_latency(input string n);
        checks++;
        if (t01 - t0 <= 2 * FRAME + 2 || t01 - t0 > DB * FRAME + 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d..%0d",
                     n, t01 - t0, 2 * FRAME + 3, DB * FRAME + 2);
        end
    endtask

    task automatic sync_frame();
        logic [3:0] prev;
        bit ok;
        prev = line;
        ok = 0;
        for (int i = 0; i < 3 * FRAME && !ok; i++) begin
            @(negedge clk);
            if (line == 4'b1110 && prev == 4'b0111) ok = 1;
            prev = line;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL sync: got no frame start within %0d cycles, required one", 3 * FRAME);
        end
    endtask

    task automatic set_vec(input int i, input string n, input logic [15:0] k, input int f,
                           input logic [1:0] fl, input logic [3:0] ky, input int ns,
                           input logic [5:0] s0, input logic [5:0] s1);
        tbl[i].name = n; tbl[i].keys = k; tbl[i].frames = f; tbl[i].flag = fl;
        tbl[i].key = ky; tbl[i].ns = ns; tbl[i].s0 = s0; tbl[i].s1 = s1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, required finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_line;
        set_vec(0, "press6",   16'h0040, 5, 2'b10, 4'd6,  1, {2'b01, 4'd6},  6'd0);
        set_vec(1, "release6", 16'h0000, 4, 2'b00, 4'd6,  1, {2'b11, 4'd6},  6'd0);
        set_vec(2, "multi",    16'h0003, 6, 2'b00, 4'd6,  0, 6'd0,           6'd0);
        set_vec(3, "clear",    16'h0000, 4, 2'b00, 4'd6,  0, 6'd0,           6'd0);
        set_vec(4, "press1",   16'h0001, 5, 2'b10, 4'd1,  1, {2'b01, 4'd1},  6'd0);
        set_vec(5, "rollA",    16'h0008, 5, 2'b10, 4'd10, 2, {2'b11, 4'd1},  {2'b01, 4'd10});
        set_vec(6, "releaseA", 16'h0000, 4, 2'b00, 4'd10, 1, {2'b11, 4'd10}, 6'd0);
        set_vec(7, "press5",   16'h0020, 5, 2'b10, 4'd5,  1, {2'b01, 4'd5},  6'd0);

        rst_n = 1'b0;
        keys  = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_line", 32'(line), 32'(4'b1110));
        chk("rst_key", 32'(keyword), 0);
        chk("rst_flag", 32'(flag_pressed), 0);
        exp_line = 4'b1110;
        repeat (3) @(negedge clk);
        for (int j = 1; j <= 4; j++) begin
            exp_line = {exp_line[2:0], exp_line[3]};
            chk("line_rotate", 32'(line), 32'(exp_line));
            repeat (4) @(negedge clk);
        end

        sync_frame();
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (FRAME) @(negedge clk);
        end
        keys = 16'h0;
        repeat (DB * FRAME + 4) @(negedge clk);
        chk("bounce_flag", 32'(flag_pressed), 0);
        chk("bounce_key", 32'(keyword), 0);
        chk_q("bounce");

        for (int i = 0; i < 8; i++) begin
            sync_frame();
            if (tbl[i].ns > 0) exp_q.push_back(tbl[i].s0);
            if (tbl[i].ns > 1) exp_q.push_back(tbl[i].s1);
            keys = tbl[i].keys;
            t0 = cyc;
            repeat (tbl[i].frames * FRAME) @(negedge clk);
            chk({tbl[i].name, "_flag"}, 32'(flag_pressed), 32'(tbl[i].flag));
            chk({tbl[i].name, "_key"}, 32'(keyword), 32'(tbl[i].key));
            chk_q(tbl[i].name);
            if (tbl[i].ns == 1 && tbl[i].s0[5:4] == 2'b01) chk_latency(tbl[i].name);
            if (tbl[i].ns == 2) chk("roll_gap", 32'(t01 - t11), 1);
        end

        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_flag", 32'(flag_pressed), 0);
        chk("midrst_key", 32'(keyword), 0);
        chk("midrst_line", 32'(line), 32'(4'b1110));
        rst_n = 1'b1;
        exp_q.push_back({2'b01, 4'd5});
        t0 = cyc;
        repeat (4 * FRAME) @(negedge clk);
        chk("redebounce_flag", 32'(flag_pressed), 32'(2'b10));
        chk("redebounce_key", 32'(keyword), 5);
        chk_q("redebounce");
        chk_latency("redebounce");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
